// File: rtl/im_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_write_ctrl_pkg
// Brief    : Shared CPU definitions for the instruction-memory write path:
//            write-sequencer state encoding, fetch NOP and IM region bounds.
// Revision : 1.0 - initial release
// ============================================================================
package im_write_ctrl_pkg;

  // Write sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4
  } im_state_e;

  // Instruction handed to fetch while the SRAM is owned by a write
  localparam logic [15:0] C_NOP_INST = 16'h0800;

  // IM address window [C_IM_BASE, C_IM_END), shared with the pause unit
  localparam logic [15:0] C_IM_BASE = 16'h4000;
  localparam logic [16:0] C_IM_END  = 17'h08000;

endpackage : im_write_ctrl_pkg
`default_nettype wire

// File: rtl/im_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : im_write_ctrl
// Brief    : Time-shares the single-port instruction SRAM between fetch and
//            store-to-IM writes. Each write runs SETUP/PULSE/HOLD on the WE
//            strobe, then pulses an acknowledge so the stalled store retires.
// Revision : 1.0 - initial release
// ============================================================================
module im_write_ctrl
  import im_write_ctrl_pkg::*;
#(
  parameter int          SETUP_CYC = 1,
  parameter int          PULSE_CYC = 2,
  parameter int          HOLD_CYC  = 1,
  parameter logic [15:0] NOP_INST  = C_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ImWrite,
  input  logic [15:0] ImWriteAddr,
  input  logic [15:0] ImWriteData,
  input  logic [15:0] PcAddr,
  output logic [15:0] RamAddr,
  output logic [15:0] RamDataOut,
  output logic        RamDataOe,
  input  logic [15:0] RamDataIn,
  output logic        RamWE_n,
  output logic        RamOE_n,
  output logic [15:0] InstOut,
  output logic        Busy,
  output logic        ImWriteAck
);

  // One shared down-counter sized for the longest phase
  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  im_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [15:0]      addr_q,  addr_d;
  logic [15:0]      data_q,  data_d;

  // State, phase counter and frozen write address/data; reset aborts a write
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state sequencing and SRAM/pipeline strobes decoded from state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    RamAddr    = addr_q;
    RamDataOut = data_q;
    RamDataOe  = 1'b0;
    RamOE_n    = 1'b1;
    RamWE_n    = 1'b1;
    InstOut    = NOP_INST;
    Busy       = 1'b1;
    ImWriteAck = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Fetch owns the SRAM; read data flows straight to IF/ID
        RamAddr = PcAddr;
        RamOE_n = 1'b0;
        InstOut = RamDataIn;
        Busy    = 1'b0;
        if (ImWrite) begin
          addr_d  = ImWriteAddr;
          data_d  = ImWriteData;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        RamDataOe = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        RamDataOe = 1'b1;
        RamWE_n   = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        RamDataOe = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ACK: begin
        // Bus released; ImWrite is ignored here so the gap cycle is IDLE
        ImWriteAck = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : im_write_ctrl
`default_nettype wire

// File: tb/tb_im_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_write_ctrl
// Brief    : Self-checking bench for im_write_ctrl: directed and random writes
//            against an SRAM model and a reference memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_write_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2, ImWrite, ImWrite2;
  logic [15:0] ImWriteAddr, ImWriteData, PcAddr, RamDataIn;

  logic [15:0] RamAddr, RamDataOut, InstOut;
  logic        RamDataOe, RamWE_n, RamOE_n, Busy, ImWriteAck;
  logic [15:0] RamAddr2, RamDataOut2, InstOut2;
  logic        RamDataOe2, RamWE_n2, RamOE_n2, Busy2, ImWriteAck2;

  always #5 clk = ~clk;

  im_write_ctrl dut (
    .clk(clk), .rst(rst), .ImWrite(ImWrite), .ImWriteAddr(ImWriteAddr),
    .ImWriteData(ImWriteData), .PcAddr(PcAddr), .RamAddr(RamAddr),
    .RamDataOut(RamDataOut), .RamDataOe(RamDataOe), .RamDataIn(RamDataIn),
    .RamWE_n(RamWE_n), .RamOE_n(RamOE_n), .InstOut(InstOut), .Busy(Busy),
    .ImWriteAck(ImWriteAck)
  );

  im_write_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst(rst2), .ImWrite(ImWrite2), .ImWriteAddr(ImWriteAddr),
    .ImWriteData(ImWriteData), .PcAddr(PcAddr), .RamAddr(RamAddr2),
    .RamDataOut(RamDataOut2), .RamDataOe(RamDataOe2), .RamDataIn(RamDataIn),
    .RamWE_n(RamWE_n2), .RamOE_n(RamOE_n2), .InstOut(InstOut2), .Busy(Busy2),
    .ImWriteAck(ImWriteAck2)
  );

  // Asynchronous SRAM model for the default instance
  logic [15:0] mem [0:65535] = '{default: 16'h0000};
  always @(posedge clk) if (!RamWE_n) mem[RamAddr] <= RamDataOut;
  assign RamDataIn = RamOE_n ? 16'h0000 : mem[RamAddr];

  // Reference image: what the IM must hold after every acknowledged write
  logic [15:0] ref_mem [int];

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;

  logic [15:0] obs_addr, obs_dout, obs_inst;
  logic        obs_doe, obs_we_n, obs_oe_n, obs_busy, obs_ack;
  assign obs_addr = sel ? RamAddr2    : RamAddr;
  assign obs_dout = sel ? RamDataOut2 : RamDataOut;
  assign obs_inst = sel ? InstOut2    : InstOut;
  assign obs_doe  = sel ? RamDataOe2  : RamDataOe;
  assign obs_we_n = sel ? RamWE_n2    : RamWE_n;
  assign obs_oe_n = sel ? RamOE_n2    : RamOE_n;
  assign obs_busy = sel ? Busy2       : Busy;
  assign obs_ack  = sel ? ImWriteAck2 : ImWriteAck;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] rnd_im_addr();
    return 16'h4000 | 16'($urandom_range(0, 16383));
  endfunction

  // Fetch-owned cycle: SRAM read-enabled, no write strobes
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, obs_busy, 16'd0);
    chk({tag, "_we_n"}, obs_we_n, 16'd1);
    chk({tag, "_oe_n"}, obs_oe_n, 16'd0);
    chk({tag, "_doe"},  obs_doe,  16'd0);
    chk({tag, "_ack"},  obs_ack,  16'd0);
    if (!sel) begin
      chk({tag, "_addr"}, obs_addr, PcAddr);
      chk({tag, "_inst"}, obs_inst, ref_rd(PcAddr));
    end
  endtask

  // Issue one write and check every cycle of its SETUP/PULSE/HOLD/ACK trace.
  // During the pulse the request inputs switch to (nxt, na, nd).
  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input bit nxt, input logic [15:0] na, input logic [15:0] nd);
    int s, p, h;
    s = sel ? 2 : 1;
    p = sel ? 3 : 2;
    h = sel ? 2 : 1;
    if (sel) ImWrite2 = 1'b1; else ImWrite = 1'b1;
    ImWriteAddr = a;
    ImWriteData = d;
    for (int i = 0; i < s + p + h; i++) begin
      @(negedge clk);
      chk("wr_busy", obs_busy, 16'd1);
      chk("wr_we_n", obs_we_n, (i >= s && i < s + p) ? 16'd0 : 16'd1);
      chk("wr_oe_n", obs_oe_n, 16'd1);
      chk("wr_doe",  obs_doe,  16'd1);
      chk("wr_ack",  obs_ack,  16'd0);
      chk("wr_inst", obs_inst, 16'h0800);
      chk("wr_addr", obs_addr, a);
      chk("wr_data", obs_dout, d);
      if (i == s) begin
        if (sel) ImWrite2 = nxt; else ImWrite = nxt;
        ImWriteAddr = na;
        ImWriteData = nd;
      end
    end
    @(negedge clk);
    chk("ack_ack",  obs_ack,  16'd1);
    chk("ack_busy", obs_busy, 16'd1);
    chk("ack_we_n", obs_we_n, 16'd1);
    chk("ack_oe_n", obs_oe_n, 16'd1);
    chk("ack_doe",  obs_doe,  16'd0);
    chk("ack_inst", obs_inst, 16'h0800);
    if (!sel) ref_mem[int'(a)] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ca, cd, na, nd;
    bit b2b;

    // Reset held with a pending request: nothing may start
    rst = 1'b0; rst2 = 1'b0; ImWrite = 1'b1; ImWrite2 = 1'b0;
    ImWriteAddr = 16'h4010; ImWriteData = 16'hBEEF; PcAddr = 16'h4000;
    repeat (2) begin
      @(negedge clk);
      idle_chk("rst");
    end

    // Release: the held request is accepted on the next edge
    rst = 1'b1;
    do_write(16'h4010, 16'hBEEF, 1'b0, 16'h5000, 16'h1234);

    // Fetch resumes in the first IDLE cycle and sees the new word
    @(negedge clk);
    PcAddr = 16'h4010;
    #1;
    idle_chk("resume");
    chk("resume_beef", InstOut, 16'hBEEF);
    @(negedge clk);
    PcAddr = 16'h5000;
    #1;
    chk("no_stray_5000", InstOut, 16'h0000);

    // Back-to-back: request held across ACK, one IDLE gap, second sequence
    do_write(16'h4020, 16'hCAFE, 1'b1, 16'h7FFF, 16'h0001);
    @(negedge clk);
    idle_chk("b2b_gap");
    do_write(16'h7FFF, 16'h0001, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    PcAddr = 16'h7FFF;
    #1;
    idle_chk("b2b_end");
    chk("b2b_word", InstOut, 16'h0001);

    // Random writes, random gaps and random back-to-back chaining
    ca = rnd_im_addr();
    cd = 16'($urandom);
    for (int k = 0; k < 24; k++) begin
      na  = rnd_im_addr();
      nd  = 16'($urandom);
      b2b = (k == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      do_write(ca, cd, b2b, na, nd);
      @(negedge clk);
      PcAddr = ca;
      #1;
      idle_chk("rnd_first_idle");
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          PcAddr = rnd_im_addr();
          #1;
          idle_chk("rnd_idle");
        end
      end
      ca = na;
      cd = nd;
    end
    ImWrite = 1'b0;

    // Every written location reads back its latest value through fetch
    foreach (ref_mem[key]) begin
      @(negedge clk);
      PcAddr = 16'(key);
      #1;
      chk("sweep", InstOut, ref_mem[key]);
    end

    // Second instance, 2/3/2 timing: one full write
    sel  = 1'b1;
    rst2 = 1'b1;
    @(negedge clk);
    idle_chk("p232_idle");
    do_write(16'h4444, 16'h5555, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    idle_chk("p232_after");

    // Reset during PULSE aborts at once with no acknowledge
    ImWrite2 = 1'b1; ImWriteAddr = 16'h4100; ImWriteData = 16'h00FF;
    repeat (3) @(negedge clk);
    chk("abort_in_pulse", obs_we_n, 16'd0);
    ImWrite2 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("abort_we_n", obs_we_n, 16'd1);
    chk("abort_busy", obs_busy, 16'd0);
    chk("abort_ack",  obs_ack,  16'd0);
    chk("abort_doe",  obs_doe,  16'd0);
    rst2 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_ack",  obs_ack,  16'd0);
      chk("post_abort_busy", obs_busy, 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_im_write_ctrl
`default_nettype wire
